apple_kbd_latch: RTL and testbench

Converts the 8-bit HID keycode driven by the Nios-written keycode PIO (plus a sibling modifier PIO) into the Apple II+ keyboard register. It sits directly downstream of the keycode PIO and upstream of the 6502 I/O decoder. It presents `{strobe, ascii[6:0]}` at $C000 and clears the strobe on any $C010 access. It detects new presses, holds the strobe until the CPU acknowledges it, and optionally generates auto-repeat.

---
 rtl/apple_kbd_latch.sv | 147 ++++++++++++++
 tb/tb_apple_kbd_latch.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/apple_kbd_latch.sv
// apple_kbd_latch: turns HID keycode/modifier PIO bytes into the Apple II+ $C000 keyboard register.
// Build with APPLE_KBD_REPEAT_EN defined to add the auto-repeat counter and REPEAT state.
module apple_kbd_latch #(
  parameter int unsigned REPEAT_DELAY_CYC  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD_CYC = 5_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] keycode,
  input  logic [7:0] modifiers,
  input  logic       strb_clr,
  output logic [7:0] kbd_data,
  output logic       key_down
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // HID usage -> 7-bit II+ ASCII; 0 means the key has no II+ equivalent.
  function automatic logic [6:0] map_key(input logic [7:0] code,
                                         input logic       shift,
                                         input logic       ctrl);
    logic [6:0] ascii;
    ascii = 7'h00;
    if (code >= 8'h04 && code <= 8'h1D) begin
      ascii = code[6:0] + 7'h3D;
      if (ctrl) ascii = ascii & 7'h1F;
    end else if (code >= 8'h1E && code <= 8'h26) begin
      ascii = code[6:0] + (shift ? 7'h03 : 7'h13);
    end else begin
      case (code)
        8'h27:   ascii = 7'h30;
        8'h28:   ascii = 7'h0D;
        8'h29:   ascii = 7'h1B;
        8'h2A:   ascii = 7'h08;
        8'h2C:   ascii = 7'h20;
        8'h50:   ascii = 7'h08;
        8'h4F:   ascii = 7'h15;
        8'h2D:   ascii = shift ? 7'h3D : 7'h2D;
        8'h2E:   ascii = shift ? 7'h2A : 7'h3A;
        8'h33:   ascii = shift ? 7'h2B : 7'h3B;
        8'h36:   ascii = shift ? 7'h3C : 7'h2C;
        8'h37:   ascii = shift ? 7'h3E : 7'h2E;
        8'h38:   ascii = shift ? 7'h3F : 7'h2F;
        default: ascii = 7'h00;
      endcase
    end
    return ascii;
  endfunction

  logic       shift;
  logic       ctrl;
  logic [6:0] map_ascii;
  logic       mappable;

  state_t     state_reg, state_next;
  logic [7:0] key_q_reg, key_q_next;
  logic [6:0] ascii_reg, ascii_next;
  logic       strobe_reg, strobe_next;

  assign shift     = modifiers[1] | modifiers[5];
  assign ctrl      = modifiers[0] | modifiers[4];
  assign map_ascii = map_key(keycode, shift, ctrl);
  assign mappable  = (map_ascii != 7'h00);

`ifdef APPLE_KBD_REPEAT_EN
  localparam int unsigned MAX_CYC = (REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC) ?
                                    REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC;
  localparam int CNT_W = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD_CYC - 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic unused_ok;
  assign unused_ok = ^{modifiers[7:6], modifiers[3:2]};
`else
  logic unused_ok;
  assign unused_ok = ^{modifiers[7:6], modifiers[3:2],
                       32'(REPEAT_DELAY_CYC), 32'(REPEAT_PERIOD_CYC)};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      key_q_reg  <= 8'h00;
      ascii_reg  <= 7'h00;
      strobe_reg <= 1'b0;
`ifdef APPLE_KBD_REPEAT_EN
      cnt_reg    <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      key_q_reg  <= key_q_next;
      ascii_reg  <= ascii_next;
      strobe_reg <= strobe_next;
`ifdef APPLE_KBD_REPEAT_EN
      cnt_reg    <= cnt_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    key_q_next  = key_q_reg;
    ascii_next  = ascii_reg;
    // A set further down overrides the CPU acknowledge in the same cycle.
    strobe_next = strobe_reg & ~strb_clr;
`ifdef APPLE_KBD_REPEAT_EN
    cnt_next    = cnt_reg;
`endif
    if (!mappable) begin
      // Forgetting key_q lets a re-press of the same key count as new.
      state_next = IDLE;
      key_q_next = 8'h00;
`ifdef APPLE_KBD_REPEAT_EN
      cnt_next   = '0;
`endif
    end else if (keycode != key_q_reg) begin
      state_next  = HELD;
      key_q_next  = keycode;
      ascii_next  = map_ascii;
      strobe_next = 1'b1;
`ifdef APPLE_KBD_REPEAT_EN
      cnt_next    = DELAY_LOAD;
`endif
    end else begin
`ifdef APPLE_KBD_REPEAT_EN
      if (cnt_reg == '0) begin
        state_next  = REPEAT;
        ascii_next  = map_ascii;
        strobe_next = 1'b1;
        cnt_next    = PERIOD_LOAD;
      end else begin
        cnt_next = cnt_reg - CNT_W'(1);
      end
`endif
    end
  end

  assign kbd_data = {strobe_reg, ascii_reg};
  assign key_down = (state_reg != IDLE);

endmodule

// File: tb/tb_apple_kbd_latch.sv
// Bench for apple_kbd_latch: vector table, randomized run against a cycle-age model, repeat/reset sequences.
module tb_apple_kbd_latch;
  localparam int DELAY  = 10;
  localparam int PERIOD = 4;
`ifdef APPLE_KBD_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [7:0] modifiers = 8'h00;
  logic       strb_clr = 1'b0;
  logic [7:0] kbd_data;
  logic       key_down;

  int total = 0;
  int bad = 0;

  apple_kbd_latch #(
    .REPEAT_DELAY_CYC (DELAY),
    .REPEAT_PERIOD_CYC(PERIOD)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .keycode  (keycode),
    .modifiers(modifiers),
    .strb_clr (strb_clr),
    .kbd_data (kbd_data),
    .key_down (key_down)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] kc;
    logic [7:0] mods;
    logic       clr;
    logic [7:0] exp_kbd;
    logic       exp_down;
  } vec_t;

  vec_t vecs[18];

  // Keyboard layout as lookup tables, filled from the key chart.
  logic [6:0] plain_tab[256];
  logic [6:0] shift_tab[256];

  task automatic set_key(input int code, input logic [6:0] p, input logic [6:0] s);
    plain_tab[code] = p;
    shift_tab[code] = s;
  endtask

  function automatic logic [6:0] ref_map(input logic [7:0] kc, input logic [7:0] mods);
    logic       sh;
    logic       ct;
    logic [6:0] a;
    sh = mods[1] | mods[5];
    ct = mods[0] | mods[4];
    a  = sh ? shift_tab[kc] : plain_tab[kc];
    if (ct && kc >= 8'h04 && kc <= 8'h1D) a = a & 7'h1F;
    return a;
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    keycode   = 8'h00;
    modifiers = 8'h00;
    strb_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {key_down, kbd_data}, 9'h000);
    reset_n = 1'b1;
  endtask

  // Reference model state: what the keyboard register should show.
  logic [7:0] m_key;
  logic [6:0] m_ascii;
  logic       m_strobe;
  int         m_age;

  task automatic model_step(input logic [7:0] kc, input logic [7:0] mods, input logic clr);
    logic [6:0] m;
    logic       set;
    m   = ref_map(kc, mods);
    set = 1'b0;
    if (m == 7'h00) begin
      m_key = 8'h00;
    end else if (kc != m_key) begin
      m_key   = kc;
      m_ascii = m;
      m_age   = 0;
      set     = 1'b1;
    end else begin
      m_age++;
      if (REP_EN && m_age >= DELAY && ((m_age - DELAY) % PERIOD) == 0) begin
        m_ascii = m;
        set     = 1'b1;
      end
    end
    m_strobe = set ? 1'b1 : (m_strobe & ~clr);
  endtask

  initial begin
    logic [7:0] pool[8];
    logic [7:0] mpool[6];
    logic [7:0] kc_now;
    logic [7:0] md_now;
    logic       exp_strb;

    for (int i = 0; i < 256; i++) set_key(i, 7'h00, 7'h00);
    for (int i = 0; i < 26; i++) set_key(8'h04 + i, 7'(8'h41 + i), 7'(8'h41 + i));
    for (int i = 0; i < 9; i++) set_key(8'h1E + i, 7'(8'h31 + i), 7'(8'h21 + i));
    set_key(8'h27, 7'h30, 7'h30);
    set_key(8'h28, 7'h0D, 7'h0D);
    set_key(8'h29, 7'h1B, 7'h1B);
    set_key(8'h2A, 7'h08, 7'h08);
    set_key(8'h2C, 7'h20, 7'h20);
    set_key(8'h50, 7'h08, 7'h08);
    set_key(8'h4F, 7'h15, 7'h15);
    set_key(8'h2D, "-", "=");
    set_key(8'h2E, ":", "*");
    set_key(8'h33, ";", "+");
    set_key(8'h36, ",", "<");
    set_key(8'h37, ".", ">");
    set_key(8'h38, "/", "?");

    vecs[0]  = '{8'h04, 8'h00, 1'b0, 8'hC1, 1'b1};
    vecs[1]  = '{8'h04, 8'h00, 1'b0, 8'hC1, 1'b1};
    vecs[2]  = '{8'h04, 8'h00, 1'b1, 8'h41, 1'b1};
    vecs[3]  = '{8'h00, 8'h00, 1'b0, 8'h41, 1'b0};
    vecs[4]  = '{8'h1F, 8'h02, 1'b0, 8'hA2, 1'b1};
    vecs[5]  = '{8'h00, 8'h00, 1'b0, 8'hA2, 1'b0};
    vecs[6]  = '{8'h06, 8'h01, 1'b0, 8'h83, 1'b1};
    vecs[7]  = '{8'h3A, 8'h00, 1'b0, 8'h83, 1'b0};
    vecs[8]  = '{8'h3A, 8'h00, 1'b1, 8'h03, 1'b0};
    vecs[9]  = '{8'h04, 8'h00, 1'b0, 8'hC1, 1'b1};
    vecs[10] = '{8'h05, 8'h00, 1'b1, 8'hC2, 1'b1};
    vecs[11] = '{8'h05, 8'h00, 1'b1, 8'h42, 1'b1};
    vecs[12] = '{8'h07, 8'h00, 1'b0, 8'hC4, 1'b1};
    vecs[13] = '{8'h00, 8'h00, 1'b0, 8'hC4, 1'b0};
    vecs[14] = '{8'h27, 8'h02, 1'b0, 8'hB0, 1'b1};
    vecs[15] = '{8'h2E, 8'h02, 1'b0, 8'hAA, 1'b1};
    vecs[16] = '{8'h4F, 8'h00, 1'b0, 8'h95, 1'b1};
    vecs[17] = '{8'h00, 8'h00, 1'b0, 8'h95, 1'b0};

    pool  = '{8'h00, 8'h04, 8'h05, 8'h1E, 8'h27, 8'h2D, 8'h3A, 8'h38};
    mpool = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h20, 8'h22};

    // Directed table
    do_reset();
    for (int i = 0; i < 18; i++) begin
      keycode   = vecs[i].kc;
      modifiers = vecs[i].mods;
      strb_clr  = vecs[i].clr;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {key_down, kbd_data}, {vecs[i].exp_down, vecs[i].exp_kbd});
    end

    // Randomized run against the model
    do_reset();
    m_key = 8'h00; m_ascii = 7'h00; m_strobe = 1'b0; m_age = 0;
    kc_now = 8'h00;
    md_now = 8'h00;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 23) == 0) kc_now = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 15) == 0) md_now = mpool[$urandom_range(0, 5)];
      keycode   = kc_now;
      modifiers = md_now;
      strb_clr  = ($urandom_range(0, 3) == 0);
      model_step(keycode, modifiers, strb_clr);
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d kc=%h", c, kc_now), {key_down, kbd_data},
            {(m_key != 8'h00), m_strobe, m_ascii});
    end

    // Auto-repeat timing with the strobe acknowledged every cycle
    do_reset();
    keycode  = 8'h2C;
    strb_clr = 1'b0;
    @(posedge clk);
    #1;
    check("rep_press", {key_down, kbd_data}, 9'h1A0);
    strb_clr = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      exp_strb = REP_EN && (k == 10 || k == 14 || k == 18);
      check($sformatf("rep_k%0d", k), {key_down, kbd_data}, {1'b1, exp_strb, 7'h20});
    end

    // Asynchronous reset while the key is still held
    #2;
    reset_n  = 1'b0;
    strb_clr = 1'b0;
    #1;
    check("async_reset", {key_down, kbd_data}, 9'h000);
    @(posedge clk);
    #1;
    check("reset_hold", {key_down, kbd_data}, 9'h000);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_press", {key_down, kbd_data}, 9'h1A0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
